coeff_bank: RTL and testbench
=============================

COEFF_BANK -- requirements
Module: coeff_bank

Interface
REQ-001 Parameter NTAP, 9, coefficients per set (>=1).
REQ-002 Parameter CW, 9, signed coefficient width.
REQ-003 Parameter PCW, 16, pixel-count width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pixel_count_valid  input  1  pixel count offered.
REQ-007 pixel_count_ready  output  1  pixel count accepted when both high.
REQ-008 pixel_count  input  PCW  number of pixels P the next coefficient set serves (unsigned).
REQ-009 coeff_valid  input  1  coefficient offered.
REQ-010 coeff_ready  output  1  coefficient accepted when both high.
REQ-011 coeff_data  input  CW  signed coefficient.
REQ-012 coeffs_valid  output  1  full coefficient set presented.
REQ-013 coeffs_ready  input  1  one pixel consumes the set when both high.
REQ-014 coeffs_data  output  NTAP x CW  unpacked array; element i = i-th accepted coefficient of the set.
REQ-015 set_done  output  1  one-cycle pulse when a set is retired.

Function
REQ-016 The block SHALL hold two coefficient banks (0,1), each with NTAP coefficients, a PCW count and a full flag.
REQ-017 Collector FSM SHALL have states C_CNT and C_COEF, plus write pointer wr_sel and coefficient index k (0..NTAP-1).
REQ-018 In C_CNT: pixel_count_ready = !full[wr_sel]; on handshake store count into bank wr_sel, k=0, go C_COEF; coeff_ready=0.
REQ-019 In C_COEF: coeff_ready=1, pixel_count_ready=0; each handshake writes coeff_data to bank[wr_sel][k], k++.
REQ-020 On the handshake with k=NTAP-1: full[wr_sel] set, wr_sel toggles, FSM returns to C_CNT (commit).
REQ-021 Issuer SHALL hold read pointer rd_sel and a PCW-bit pixel counter n.
REQ-022 coeffs_valid = full[rd_sel] && count[rd_sel]!=0; coeffs_data = bank[rd_sel] contents, stable while coeffs_valid=1.
REQ-023 Each coeffs handshake increments n; the handshake with n=count-1 retires the bank: full[rd_sel] cleared, rd_sel toggles, n=0, set_done=1 next cycle.
REQ-024 A full bank with count 0 SHALL retire one cycle after it becomes full[rd_sel], without asserting coeffs_valid, and pulse set_done.
REQ-025 Latency: with issuer idle, coeffs_valid SHALL rise the cycle after the last coefficient handshake.
REQ-026 Back-to-back: consecutive sets SHALL issue with no bubble when the next bank is already full at retirement.
REQ-027 Collection of set k+1 SHALL proceed concurrently with issue of set k; a third set stalls in C_CNT (pixel_count_ready=0) until a bank frees.
REQ-028 Simultaneous commit and retire in one cycle SHALL both take effect; full flags never lost or double-set.
REQ-029 A full bank's contents SHALL never be written.
REQ-030 coeff_valid while in C_CNT SHALL be ignored (not accepted); pixel_count_valid in C_COEF likewise.
REQ-031 No arithmetic on coefficients; values pass bit-exact.

Reset
REQ-032 On rst: FSM=C_CNT, wr_sel=rd_sel=0, k=n=0, both full flags 0, set_done=0, coeffs_valid=0, coeff_ready=0, pixel_count_ready=1 after release.
REQ-033 Bank data SHALL reset to 0, so coeffs_data reads all-zero after reset.
REQ-034 Reset mid-collection or mid-issue SHALL discard partial and pending sets; no set_done for them.

Verification
REQ-035 P=3, coeffs 1..9 (NTAP=9), coeffs_ready=1 -> coeffs_valid high exactly 3 cycles from cycle after 9th coeff, data {1..9}, set_done once.
REQ-036 Coeffs -1..-9 (0x1FF..0x1F7), P=2, coeffs_ready toggling 1/0 -> data held stable across stalls, exactly 2 handshakes, then valid low.
REQ-037 Three sets P=4 each back-to-back with coeffs_ready=0 -> third pixel_count stalled until ready raised; then 12 contiguous handshakes, three set_done pulses, correct data per set.
REQ-038 P=0 set followed by P=1 set -> no coeffs_valid for first, set_done pulse, second set issued once.
REQ-039 rst asserted after 5 of 9 coeffs while bank 0 issuing -> all outputs zero immediately; new P=1 set afterward fills bank 0 and issues correctly.
REQ-040 Parameters NTAP=4, CW=12, PCW=8, P=255 -> 255 handshakes, set_done once.

Source files
------------

// File: rtl/coeff_bank.sv
// coeff_bank: double-buffered coefficient store.
// A collector fills one of two banks with a pixel count P followed by NTAP
// signed coefficients. An issuer presents a full bank's coefficients for P
// pixel handshakes, then retires the bank.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   pixel_count_valid/_ready/    pixel count P for the next set (unsigned)
//   pixel_count
//   coeff_valid/_ready/_data     one coefficient per handshake
//   coeffs_valid/_ready/_data    full coefficient set, one pixel per handshake
//   set_done                     one-cycle pulse after a set is retired
module coeff_bank #(
  parameter int unsigned NTAP = 9,
  parameter int unsigned CW   = 9,
  parameter int unsigned PCW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pixel_count_valid,
  output logic           pixel_count_ready,
  input  logic [PCW-1:0] pixel_count,
  input  logic           coeff_valid,
  output logic           coeff_ready,
  input  logic [CW-1:0]  coeff_data,
  output logic           coeffs_valid,
  input  logic           coeffs_ready,
  output logic [CW-1:0]  coeffs_data [NTAP],
  output logic           set_done
);

  localparam int unsigned KW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NTAP - 1);

  typedef enum logic {C_CNT, C_COEF} cstate_e;

  cstate_e        state_q, state_d;
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  logic [KW-1:0]  k_q, k_d;
  logic [PCW-1:0] n_q, n_d;
  logic [1:0]     full_q, full_d;
  logic [PCW-1:0] cnt_q [2];
  logic [CW-1:0]  bank_q [2][NTAP];
  logic           set_done_q;

  logic           pc_rdy;
  logic           c_rdy;
  logic           cnt_we;
  logic           coef_we;
  logic           commit;
  logic [PCW-1:0] cur_cnt;
  logic           cur_full;
  logic           valid_c;
  logic           hs;
  logic           retire;

  // Collector: count phase then NTAP coefficient handshakes into bank wr_sel.
  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    k_d      = k_q;
    pc_rdy   = 1'b0;
    c_rdy    = 1'b0;
    cnt_we   = 1'b0;
    coef_we  = 1'b0;
    commit   = 1'b0;
    case (state_q)
      C_CNT: begin
        pc_rdy = !full_q[wr_sel_q];
        if (pixel_count_valid && pc_rdy) begin
          cnt_we  = 1'b1;
          k_d     = '0;
          state_d = C_COEF;
        end
      end
      C_COEF: begin
        c_rdy = 1'b1;
        if (coeff_valid) begin
          coef_we = 1'b1;
          if (k_q == K_LAST) begin
            commit   = 1'b1;
            wr_sel_d = !wr_sel_q;
            k_d      = '0;
            state_d  = C_CNT;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = C_CNT;
    endcase
  end

  // Issuer: a zero-count bank retires on its own without presenting valid.
  always_comb begin
    cur_cnt  = cnt_q[rd_sel_q];
    cur_full = full_q[rd_sel_q];
    valid_c  = cur_full && (cur_cnt != '0);
    hs       = valid_c && coeffs_ready;
    retire   = (hs && (n_q == cur_cnt - PCW'(1))) || (cur_full && (cur_cnt == '0));
    rd_sel_d = rd_sel_q;
    n_d      = n_q;
    if (retire) begin
      rd_sel_d = !rd_sel_q;
      n_d      = '0;
    end else if (hs) begin
      n_d = n_q + PCW'(1);
    end
  end

  // Commit only targets a non-full bank and retire only a full one, so the
  // two updates never collide on the same flag.
  always_comb begin
    full_d = full_q;
    if (commit) full_d[wr_sel_q] = 1'b1;
    if (retire) full_d[rd_sel_q] = 1'b0;
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= C_CNT;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      k_q        <= '0;
      n_q        <= '0;
      full_q     <= '0;
      set_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      k_q        <= k_d;
      n_q        <= n_d;
      full_q     <= full_d;
      set_done_q <= retire;
    end
  end

  // Bank storage; writes only reach the bank being collected, which is never full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        for (int unsigned i = 0; i < NTAP; i++) bank_q[b][i] <= '0;
      end
    end else begin
      if (cnt_we)  cnt_q[wr_sel_q] <= pixel_count;
      if (coef_we) bank_q[wr_sel_q][k_q] <= coeff_data;
    end
  end

  // Outputs; pixel_count_ready is held low while reset is asserted.
  always_comb begin
    for (int unsigned i = 0; i < NTAP; i++) coeffs_data[i] = bank_q[rd_sel_q][i];
  end

  assign pixel_count_ready = pc_rdy && !rst;
  assign coeff_ready       = c_rdy;
  assign coeffs_valid      = valid_c;
  assign set_done          = set_done_q;

endmodule

// File: tb/tb_coeff_bank.sv
`timescale 1ns/1ps
module tb_coeff_bank;

  localparam int unsigned NTAP   = 9;
  localparam int unsigned CW     = 9;
  localparam int unsigned PCW    = 16;
  localparam int unsigned S_NTAP = 4;
  localparam int unsigned S_CW   = 12;
  localparam int unsigned S_PCW  = 8;

  typedef logic [NTAP*CW-1:0]     pack_t;
  typedef logic [S_NTAP*S_CW-1:0] spack_t;

  logic clk, rst;

  logic           pixel_count_valid, pixel_count_ready;
  logic [PCW-1:0] pixel_count;
  logic           coeff_valid, coeff_ready;
  logic [CW-1:0]  coeff_data;
  logic           coeffs_valid, coeffs_ready;
  logic [CW-1:0]  coeffs_data [NTAP];
  logic           set_done;

  logic             s_pcv, s_pcr;
  logic [S_PCW-1:0] s_pc;
  logic             s_cv, s_cr;
  logic [S_CW-1:0]  s_cd;
  logic             s_csv, s_csr;
  logic [S_CW-1:0]  s_csd [S_NTAP];
  logic             s_sd;

  int checks = 0;
  int errors = 0;

  pack_t hs_q[$];
  int    hs_cyc[$];
  int    cyc, vcyc, sd;
  int    s_hs, s_sd_n, s_bad;
  spack_t s_exp;

  coeff_bank #(.NTAP(NTAP), .CW(CW), .PCW(PCW)) dut (
    .clk(clk), .rst(rst),
    .pixel_count_valid(pixel_count_valid), .pixel_count_ready(pixel_count_ready),
    .pixel_count(pixel_count),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_data(coeff_data),
    .coeffs_valid(coeffs_valid), .coeffs_ready(coeffs_ready), .coeffs_data(coeffs_data),
    .set_done(set_done)
  );

  coeff_bank #(.NTAP(S_NTAP), .CW(S_CW), .PCW(S_PCW)) dut2 (
    .clk(clk), .rst(rst),
    .pixel_count_valid(s_pcv), .pixel_count_ready(s_pcr), .pixel_count(s_pc),
    .coeff_valid(s_cv), .coeff_ready(s_cr), .coeff_data(s_cd),
    .coeffs_valid(s_csv), .coeffs_ready(s_csr), .coeffs_data(s_csd),
    .set_done(s_sd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pack_t cur_pack();
    pack_t p;
    for (int i = 0; i < NTAP; i++) p[i*CW +: CW] = coeffs_data[i];
    return p;
  endfunction

  function automatic spack_t s_pack();
    spack_t p;
    for (int i = 0; i < S_NTAP; i++) p[i*S_CW +: S_CW] = s_csd[i];
    return p;
  endfunction

  // Expected set: element i = base + step*i, truncated to CW bits.
  function automatic pack_t pk(input int base, input int step);
    pack_t p;
    for (int i = 0; i < NTAP; i++) p[i*CW +: CW] = CW'(base + step * i);
    return p;
  endfunction

  // Handshake observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (coeffs_valid) vcyc++;
      if (coeffs_valid && coeffs_ready) begin
        hs_q.push_back(cur_pack());
        hs_cyc.push_back(cyc);
      end
      if (set_done) sd++;
      if (s_csv && s_csr) begin
        s_hs++;
        if (s_pack() !== s_exp) s_bad++;
      end
      if (s_sd) s_sd_n++;
    end
  end

  task automatic clr();
    hs_q.delete();
    hs_cyc.delete();
    vcyc = 0;
    sd   = 0;
  endtask

  task automatic send_count(input int p);
    bit ok = 0;
    pixel_count       = PCW'(p);
    pixel_count_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pixel_count_ready) ok = 1;
      @(posedge clk); #1;
    end
    pixel_count_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL count_accept got timeout want handshake"); end
  endtask

  task automatic send_coeff(input int v);
    bit ok = 0;
    coeff_data  = CW'(v);
    coeff_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (coeff_ready) ok = 1;
      @(posedge clk); #1;
    end
    coeff_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL coeff_accept got timeout want handshake"); end
  endtask

  task automatic send_set(input int p, input int base, input int step);
    send_count(p);
    for (int i = 0; i < NTAP; i++) send_coeff(base + step * i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pixel_count_ready !== 1'b0) begin errors++; $display("FAIL rst_pcr_during got %b want 0", pixel_count_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (pixel_count_ready !== 1'b1) begin errors++; $display("FAIL rst_pcr got %b want 1", pixel_count_ready); end
    checks++;
    if (coeff_ready !== 1'b0) begin errors++; $display("FAIL rst_cr got %b want 0", coeff_ready); end
    checks++;
    if (coeffs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", coeffs_valid); end
    checks++;
    if (set_done !== 1'b0) begin errors++; $display("FAIL rst_set_done got %b want 0", set_done); end
    checks++;
    if (cur_pack() !== '0) begin errors++; $display("FAIL rst_data got %h want 0", cur_pack()); end
  endtask

  task automatic test_basic();
    clr();
    coeffs_ready = 1'b1;
    coeff_valid  = 1'b1;
    coeff_data   = CW'(85);
    @(negedge clk);
    checks++;
    if (coeff_ready !== 1'b0) begin errors++; $display("FAIL ignore_coeff got %b want 0", coeff_ready); end
    @(posedge clk); #1;
    coeff_valid = 1'b0;
    send_set(3, 1, 1);
    checks++;
    if (coeffs_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", coeffs_valid); end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (vcyc != 3) begin errors++; $display("FAIL basic_valid_cycles got %0d want 3", vcyc); end
    checks++;
    if (hs_q.size() != 3) begin errors++; $display("FAIL basic_hs got %0d want 3", hs_q.size()); end
    for (int i = 0; i < hs_q.size(); i++) begin
      checks++;
      if (hs_q[i] !== pk(1, 1)) begin errors++; $display("FAIL basic_data got %h want %h", hs_q[i], pk(1, 1)); end
    end
    if (hs_cyc.size() == 3) begin
      checks++;
      if (hs_cyc[2] - hs_cyc[0] != 2) begin errors++; $display("FAIL basic_contig got %0d want 2", hs_cyc[2] - hs_cyc[0]); end
    end
    checks++;
    if (sd != 1) begin errors++; $display("FAIL basic_set_done got %0d want 1", sd); end
  endtask

  task automatic test_stall();
    pack_t exp_p;
    exp_p = pk(-1, -1);
    clr();
    coeffs_ready = 1'b0;
    send_set(2, -1, -1);
    for (int i = 0; i < 8; i++) begin
      coeffs_ready = (i % 2 == 0);
      @(negedge clk);
      if (coeffs_valid) begin
        checks++;
        if (cur_pack() !== exp_p) begin errors++; $display("FAIL stall_stable got %h want %h", cur_pack(), exp_p); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (hs_q.size() != 2) begin errors++; $display("FAIL stall_hs got %0d want 2", hs_q.size()); end
    checks++;
    if (vcyc != 3) begin errors++; $display("FAIL stall_valid_cycles got %0d want 3", vcyc); end
    checks++;
    if (sd != 1) begin errors++; $display("FAIL stall_set_done got %0d want 1", sd); end
    checks++;
    if (coeffs_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_end got %b want 0", coeffs_valid); end
    coeffs_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    clr();
    coeffs_ready = 1'b0;
    send_set(4, 10, 1);
    send_set(4, 20, 1);
    pixel_count       = PCW'(4);
    pixel_count_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pixel_count_ready !== 1'b0) begin errors++; $display("FAIL b2b_third_stall got %b want 0", pixel_count_ready); end
    checks++;
    if (coeffs_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held got %b want 1", coeffs_valid); end
    @(posedge clk); #1;
    coeffs_ready = 1'b1;
    send_set(4, 30, 1);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() != 12) begin errors++; $display("FAIL b2b_hs got %0d want 12", hs_q.size()); end
    for (int i = 0; i < hs_q.size() && i < 12; i++) begin
      checks++;
      if (hs_q[i] !== pk(10 + 10 * (i / 4), 1)) begin
        errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, hs_q[i], pk(10 + 10 * (i / 4), 1));
      end
    end
    if (hs_cyc.size() >= 8) begin
      checks++;
      if (hs_cyc[7] - hs_cyc[0] != 7) begin errors++; $display("FAIL b2b_no_bubble got %0d want 7", hs_cyc[7] - hs_cyc[0]); end
    end
    checks++;
    if (sd != 3) begin errors++; $display("FAIL b2b_set_done got %0d want 3", sd); end
  endtask

  task automatic test_zero_count();
    clr();
    coeffs_ready = 1'b1;
    send_set(0, 40, 1);
    checks++;
    if (coeffs_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %b want 0", coeffs_valid); end
    @(negedge clk);
    checks++;
    if (set_done !== 1'b0) begin errors++; $display("FAIL zero_done_early got %b want 0", set_done); end
    @(negedge clk);
    checks++;
    if (set_done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", set_done); end
    @(posedge clk); #1;
    send_set(1, 50, 1);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() != 1) begin errors++; $display("FAIL zero_next_hs got %0d want 1", hs_q.size()); end
    else begin
      checks++;
      if (hs_q[0] !== pk(50, 1)) begin errors++; $display("FAIL zero_next_data got %h want %h", hs_q[0], pk(50, 1)); end
    end
    checks++;
    if (vcyc != 1) begin errors++; $display("FAIL zero_valid_cycles got %0d want 1", vcyc); end
    checks++;
    if (sd != 2) begin errors++; $display("FAIL zero_set_done got %0d want 2", sd); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    coeffs_ready = 1'b0;
    send_set(5, 60, 1);
    send_count(1);
    for (int i = 0; i < 5; i++) send_coeff(70 + i);
    rst = 1'b1;
    #1;
    checks++;
    if (coeffs_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", coeffs_valid); end
    checks++;
    if (coeff_ready !== 1'b0) begin errors++; $display("FAIL mid_cr got %b want 0", coeff_ready); end
    checks++;
    if (pixel_count_ready !== 1'b0) begin errors++; $display("FAIL mid_pcr got %b want 0", pixel_count_ready); end
    checks++;
    if (cur_pack() !== '0) begin errors++; $display("FAIL mid_data got %h want 0", cur_pack()); end
    @(posedge clk); #1;
    rst = 1'b0;
    coeffs_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() != 0 || sd != 0) begin errors++; $display("FAIL mid_discard got hs=%0d done=%0d want 0 0", hs_q.size(), sd); end
    send_set(1, 80, 1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (hs_q.size() != 1) begin errors++; $display("FAIL mid_new_hs got %0d want 1", hs_q.size()); end
    else begin
      checks++;
      if (hs_q[0] !== pk(80, 1)) begin errors++; $display("FAIL mid_new_data got %h want %h", hs_q[0], pk(80, 1)); end
    end
    checks++;
    if (sd != 1) begin errors++; $display("FAIL mid_set_done got %0d want 1", sd); end
  endtask

  task automatic test_small_params();
    logic [S_CW-1:0] vals [S_NTAP];
    bit ok;
    vals[0] = 12'h800; vals[1] = 12'h7FF; vals[2] = 12'h123; vals[3] = 12'hFED;
    s_exp = {vals[3], vals[2], vals[1], vals[0]};
    s_hs = 0; s_sd_n = 0; s_bad = 0;
    s_csr = 1'b1;
    s_pc  = S_PCW'(255);
    s_pcv = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (s_pcr) ok = 1;
      @(posedge clk); #1;
    end
    s_pcv = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL small_count got timeout want handshake"); end
    s_cv = 1'b1;
    for (int i = 0; i < S_NTAP; i++) begin
      s_cd = vals[i];
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        if (s_cr) ok = 1;
        @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL small_coeff got timeout want handshake"); end
    end
    s_cv = 1'b0;
    repeat (270) @(posedge clk);
    #1;
    checks++;
    if (s_hs != 255) begin errors++; $display("FAIL small_hs got %0d want 255", s_hs); end
    checks++;
    if (s_sd_n != 1) begin errors++; $display("FAIL small_set_done got %0d want 1", s_sd_n); end
    checks++;
    if (s_bad != 0) begin errors++; $display("FAIL small_data got %0d bad want 0", s_bad); end
    checks++;
    if (s_csv !== 1'b0) begin errors++; $display("FAIL small_valid_end got %b want 0", s_csv); end
  endtask

  initial begin
    rst = 1'b1;
    pixel_count_valid = 1'b0; pixel_count = '0;
    coeff_valid = 1'b0; coeff_data = '0; coeffs_ready = 1'b0;
    s_pcv = 1'b0; s_pc = '0; s_cv = 1'b0; s_cd = '0; s_csr = 1'b0;
    s_exp = '0; s_hs = 0; s_sd_n = 0; s_bad = 0;
    cyc = 0; vcyc = 0; sd = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_zero_count();
    test_reset_mid();
    test_small_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
